// File: rtl/spi_slave_sync.sv
// SPI mode-0 target shift engine with pins oversampled into clk_i, MSB-first words.
// Latency: received word appears on rx_data_o 1 clk after the synchronized last SCLK rise
//          (about 3 clk after the pin edge). MISO updates 1 clk after a synchronized SCLK fall.
// Backpressure: TX pops a word only at load events (underrun loads FILL_WORD). The RX holder
//               drops a new word and sets overflow_o when it is still full and not being read.
//
// Ports:
//   clk_i, rst_ni, clr_i        clock, async active-low reset, sync clear
//   spi_sclk_i/csn_i/mosi_i     asynchronous SPI pins from the master
//   spi_miso_o, spi_miso_oe_o   serial data to the master and its output enable
//   tx_data_i/valid_i/ready_o   TX word stream; ready pulses in the cycle a word is loaded
//   rx_data_o/valid_o/ready_i   RX word stream
//   busy_o, underrun_o, overflow_o  frame active, sticky underrun, sticky RX drop
module spi_slave_sync #(
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter int unsigned            LOG_DATA_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0]  FILL_WORD      = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  spi_sclk_i,
  input  logic                  spi_csn_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  busy_o,
  output logic                  underrun_o,
  output logic                  overflow_o
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [LOG_DATA_WIDTH-1:0] LAST_BIT = LOG_DATA_WIDTH'(DATA_WIDTH - 1);

  state_t                    r_state;
  logic                      r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic                      r_csn_s1, r_csn_s2, r_csn_d;
  logic                      r_mosi_s1, r_mosi_s2;
  logic                      r_init;
  logic                      r_armed;
  logic [DATA_WIDTH-1:0]     r_tx_shift;
  logic [DATA_WIDTH-2:0]     r_rx_shift;
  logic [LOG_DATA_WIDTH-1:0] r_bit_cnt;
  logic                      r_load_pend;
  logic [DATA_WIDTH-1:0]     r_rx_data;
  logic                      r_rx_valid;
  logic                      r_underrun;
  logic                      r_overflow;

  logic                      w_active;
  logic                      w_sclk_rise, w_sclk_fall;
  logic                      w_cs_fall, w_cs_rise;
  logic                      w_load, w_shift;
  logic                      w_rx_done, w_rx_xfer;
  logic [DATA_WIDTH-1:0]     w_rx_word;

  assign w_active    = (r_state == ACTIVE);
  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
  // A frame may only start once CS has been seen high after reset/clear, so a
  // reset taken mid-frame never re-enters a frame the master already started.
  assign w_cs_fall   = ~r_csn_s2 & r_csn_d & r_armed;
  assign w_cs_rise   = r_csn_s2 & ~r_csn_d;

  // cs_rise wins over any SCLK edge seen in the same cycle.
  assign w_load    = (~w_active & w_cs_fall) |
                     (w_active & ~w_cs_rise & w_sclk_fall & r_load_pend);
  assign w_shift   = w_active & ~w_cs_rise & w_sclk_fall & ~r_load_pend;
  assign w_rx_word = {r_rx_shift, r_mosi_s2};
  assign w_rx_done = w_active & ~w_cs_rise & w_sclk_rise & (r_bit_cnt == LAST_BIT);
  assign w_rx_xfer = r_rx_valid & rx_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_sclk_s1   <= 1'b0;
      r_sclk_s2   <= 1'b0;
      r_sclk_d    <= 1'b0;
      r_csn_s1    <= 1'b1;
      r_csn_s2    <= 1'b1;
      r_csn_d     <= 1'b1;
      r_mosi_s1   <= 1'b0;
      r_mosi_s2   <= 1'b0;
      r_init      <= 1'b0;
      r_armed     <= 1'b0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_bit_cnt   <= '0;
      r_load_pend <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (clr_i) begin
      r_state     <= IDLE;
      r_sclk_s1   <= 1'b0;
      r_sclk_s2   <= 1'b0;
      r_sclk_d    <= 1'b0;
      r_csn_s1    <= 1'b1;
      r_csn_s2    <= 1'b1;
      r_csn_d     <= 1'b1;
      r_mosi_s1   <= 1'b0;
      r_mosi_s2   <= 1'b0;
      r_init      <= 1'b0;
      r_armed     <= 1'b0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_bit_cnt   <= '0;
      r_load_pend <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_sclk_s1 <= spi_sclk_i;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_csn_s1  <= spi_csn_i;
      r_csn_s2  <= r_csn_s1;
      r_csn_d   <= r_csn_s2;
      r_mosi_s1 <= spi_mosi_i;
      r_mosi_s2 <= r_mosi_s1;

      // r_init blocks arming on the reset values still held in the chain;
      // arming needs the pin itself to have propagated high through it.
      r_init <= 1'b1;
      if (r_init && r_csn_s1 && r_csn_s2 && r_csn_d) begin
        r_armed <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_state     <= ACTIVE;
            r_bit_cnt   <= '0;
            r_load_pend <= 1'b0;
            r_rx_shift  <= '0;
          end
        end
        ACTIVE: begin
          if (w_cs_rise) begin
            // Abort or normal end: drop any partial RX word silently.
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_load_pend <= 1'b0;
            r_rx_shift  <= '0;
          end else begin
            if (w_sclk_rise) begin
              r_rx_shift <= w_rx_word[DATA_WIDTH-2:0];
              if (r_bit_cnt == LAST_BIT) begin
                r_bit_cnt   <= '0;
                r_load_pend <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + LOG_DATA_WIDTH'(1);
              end
            end
            if (w_sclk_fall) begin
              r_load_pend <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_load) begin
        r_tx_shift <= tx_valid_i ? tx_data_i : FILL_WORD;
        if (!tx_valid_i) begin
          r_underrun <= 1'b1;
        end
      end else if (w_shift) begin
        r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
      end

      if (w_rx_done) begin
        if (!r_rx_valid || rx_ready_i) begin
          r_rx_data  <= w_rx_word;
          r_rx_valid <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (w_rx_xfer) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign spi_miso_o    = w_active & r_tx_shift[DATA_WIDTH-1];
  assign spi_miso_oe_o = w_active;
  assign busy_o        = w_active;
  assign tx_ready_o    = w_load;
  assign rx_data_o     = r_rx_data;
  assign rx_valid_o    = r_rx_valid;
  assign underrun_o    = r_underrun;
  assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_spi_slave_sync.sv
module tb_spi_slave_sync;

  localparam logic [31:0] FILL = 32'hFFFF_FFFF;

  logic        clk_i = 1'b0;
  logic        rst_ni, clr_i;
  logic        spi_sclk_i, spi_csn_i, spi_mosi_i;
  logic        spi_miso_o, spi_miso_oe_o;
  logic [31:0] tx_data_i;
  logic        tx_valid_i, tx_ready_o;
  logic [31:0] rx_data_o;
  logic        rx_valid_o, rx_ready_i;
  logic        busy_o, underrun_o, overflow_o;

  spi_slave_sync #(.DATA_WIDTH(32), .LOG_DATA_WIDTH(5), .FILL_WORD(FILL)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i),
    .spi_sclk_i(spi_sclk_i), .spi_csn_i(spi_csn_i), .spi_mosi_i(spi_mosi_i),
    .spi_miso_o(spi_miso_o), .spi_miso_oe_o(spi_miso_oe_o),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .busy_o(busy_o), .underrun_o(underrun_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: TX source queue, words the master should see on
  // MISO, words the RX stream should deliver, and the sticky underrun flag.
  logic [31:0] tx_q[$];
  logic [31:0] exp_miso_q[$];
  logic [31:0] exp_rx_q[$];
  logic [31:0] frame_words[$];
  int          tx_pops = 0;
  bit          mdl_underrun = 0;
  int          rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready
  int          last_lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic half();
    repeat (5) @(posedge clk_i);
    #2;
  endtask

  // Stream monitor/driver: samples at negedge, updates inputs just after posedge.
  initial begin : monitor
    logic        s_rdy, s_hs;
    logic [31:0] s_dat;
    tx_valid_i = 1'b0;
    tx_data_i  = '0;
    rx_ready_i = 1'b1;
    forever begin
      @(negedge clk_i);
      s_rdy = tx_ready_o;
      s_hs  = rx_valid_o & rx_ready_i;
      s_dat = rx_data_o;
      if (s_hs) begin
        check("rx_expected", 32'(exp_rx_q.size() > 0), 32'd1);
        if (exp_rx_q.size() > 0) check("rx_word", s_dat, exp_rx_q.pop_front());
      end
      @(posedge clk_i);
      #1;
      if (s_rdy) begin
        tx_pops++;
        if (tx_q.size() > 0) exp_miso_q.push_back(tx_q.pop_front());
        else begin
          exp_miso_q.push_back(FILL);
          mdl_underrun = 1'b1;
        end
      end
      tx_valid_i = (tx_q.size() > 0);
      tx_data_i  = (tx_q.size() > 0) ? tx_q[0] : $urandom;
      case (rdy_mode)
        0:       rx_ready_i = ($urandom_range(0, 3) != 0);
        1:       rx_ready_i = 1'b1;
        default: rx_ready_i = 1'b0;
      endcase
    end
  end

  // Mode-0 master at clk/10. The final SCLK fall coincides with CS rising.
  task automatic spi_frame(input int nbits, input bit push_rx);
    logic [31:0] rw;
    int w;
    rw = '0;
    spi_csn_i = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      w = i / 32;
      spi_mosi_i = frame_words[w][31 - (i % 32)];
      half();
      rw = {rw[30:0], spi_miso_o};
      spi_sclk_i = 1'b1;
      if (i % 32 == 31) begin
        check("miso_expected", 32'(exp_miso_q.size() > 0), 32'd1);
        if (exp_miso_q.size() > 0) check("miso_word", rw, exp_miso_q.pop_front());
        if (push_rx) exp_rx_q.push_back(frame_words[w]);
      end
      if (i == nbits - 1) begin
        last_lat = -1;
        for (int c = 1; c <= 5; c++) begin
          @(posedge clk_i);
          #2;
          if (last_lat < 0 && rx_valid_o) last_lat = c;
        end
        spi_sclk_i = 1'b0;
        spi_csn_i  = 1'b1;
      end else begin
        half();
        spi_sclk_i = 1'b0;
      end
    end
    half();
    half();
    exp_miso_q.delete();
  endtask

  task automatic rx_drain();
    for (int c = 0; c < 100 && exp_rx_q.size() > 0; c++) @(posedge clk_i);
    check("rx_drain", 32'(exp_rx_q.size()), 32'd0);
  endtask

  task automatic clr_pulse();
    @(posedge clk_i);
    #2;
    clr_i = 1'b1;
    @(posedge clk_i);
    #2;
    clr_i = 1'b0;
    mdl_underrun = 1'b0;
    repeat (4) @(posedge clk_i);
    #2;
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int p0, nw;
    rst_ni = 1'b0;
    clr_i = 1'b0;
    spi_sclk_i = 1'b0;
    spi_csn_i = 1'b1;
    spi_mosi_i = 1'b0;
    #23;
    check("rst_busy", 32'(busy_o), 0);
    check("rst_oe", 32'(spi_miso_oe_o), 0);
    check("rst_miso", 32'(spi_miso_o), 0);
    check("rst_tx_ready", 32'(tx_ready_o), 0);
    check("rst_rx_valid", 32'(rx_valid_o), 0);
    check("rst_rx_data", rx_data_o, 0);
    check("rst_underrun", 32'(underrun_o), 0);
    check("rst_overflow", 32'(overflow_o), 0);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    repeat (6) @(posedge clk_i);
    #2;

    // Single frame.
    rdy_mode = 1;
    tx_q.push_back(32'hA5A5_0F0F);
    frame_words = '{32'h1234_5678};
    p0 = tx_pops;
    spi_frame(32, 1);
    check("single_tx_pops", 32'(tx_pops - p0), 1);
    check("single_rx_lat_ok", 32'(last_lat >= 1 && last_lat <= 4), 1);
    rx_drain();

    // Back-to-back words in one frame.
    tx_q.push_back(32'h0000_0001);
    tx_q.push_back(32'h0000_0002);
    frame_words = '{$urandom, $urandom};
    p0 = tx_pops;
    spi_frame(64, 1);
    check("b2b_tx_pops", 32'(tx_pops - p0), 2);
    rx_drain();

    // Underrun.
    frame_words = '{$urandom};
    spi_frame(32, 1);
    rx_drain();
    check("underrun_set", 32'(underrun_o), 32'(mdl_underrun));
    repeat (20) @(posedge clk_i);
    #2;
    check("underrun_sticky", 32'(underrun_o), 1);
    clr_pulse();
    check("underrun_clr", 32'(underrun_o), 32'(mdl_underrun));

    // Overflow with RX held off.
    rdy_mode = 2;
    repeat (2) @(posedge clk_i);
    #2;
    tx_q.push_back($urandom);
    tx_q.push_back($urandom);
    frame_words = '{32'h1111_1111, 32'h2222_2222};
    spi_frame(64, 0);
    check("ovf_rx_valid", 32'(rx_valid_o), 1);
    check("ovf_rx_data", rx_data_o, 32'h1111_1111);
    check("ovf_flag", 32'(overflow_o), 1);
    exp_rx_q.push_back(32'h1111_1111);
    rdy_mode = 1;
    repeat (3) @(posedge clk_i);
    #2;
    check("ovf_rx_drained", 32'(rx_valid_o), 0);
    rx_drain();
    clr_pulse();
    check("ovf_clr", 32'(overflow_o), 0);

    // Abort after 10 SCLKs, then a good frame.
    tx_q.push_back($urandom);
    frame_words = '{$urandom};
    p0 = tx_pops;
    spi_frame(10, 1);
    check("abort_busy", 32'(busy_o), 0);
    check("abort_rx_valid", 32'(rx_valid_o), 0);
    check("abort_tx_pops", 32'(tx_pops - p0), 1);
    check("abort_underrun", 32'(underrun_o), 0);
    tx_q.push_back($urandom);
    frame_words = '{32'hCAFE_BABE};
    spi_frame(32, 1);
    rx_drain();

    // Reset after 5 bits.
    tx_q.push_back($urandom);
    frame_words = '{$urandom};
    spi_csn_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      spi_mosi_i = frame_words[0][31 - i];
      half();
      spi_sclk_i = 1'b1;
      half();
      spi_sclk_i = 1'b0;
    end
    #3;
    rst_ni = 1'b0;
    #1;
    check("rstmid_oe", 32'(spi_miso_oe_o), 0);
    check("rstmid_busy", 32'(busy_o), 0);
    check("rstmid_miso", 32'(spi_miso_o), 0);
    check("rstmid_rx_valid", 32'(rx_valid_o), 0);
    mdl_underrun = 1'b0;
    exp_miso_q.delete();
    repeat (3) @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    repeat (10) @(posedge clk_i);
    #2;
    check("rstmid_no_restart", 32'(busy_o), 0);
    spi_csn_i = 1'b1;
    half();
    exp_miso_q.delete();
    tx_q.push_back($urandom);
    frame_words = '{$urandom};
    spi_frame(32, 1);
    rx_drain();

    // Randomized frames with random RX backpressure.
    rdy_mode = 0;
    for (int f = 0; f < 8; f++) begin
      nw = $urandom_range(1, 3);
      frame_words.delete();
      for (int k = 0; k < nw; k++) begin
        tx_q.push_back($urandom);
        frame_words.push_back($urandom);
      end
      p0 = tx_pops;
      spi_frame(32 * nw, 1);
      check("rand_tx_pops", 32'(tx_pops - p0), 32'(nw));
      rx_drain();
    end
    check("rand_underrun", 32'(underrun_o), 32'(mdl_underrun));
    check("rand_overflow", 32'(overflow_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_slave_sync.md
Name: spi_slave_sync

Overview:
- Single-clock SPI target (slave) shift engine that sits on the far end of the bus from our SPI master.
- Oversamples the SPI pins into clk_i and shifts words MSB-first in SPI mode 0 (CPOL=0, CPHA=0).
- TX side pops words from a valid/ready stream, normally the output of a spi_master_fifo instance.
- RX side pushes completed words into a valid/ready stream, normally the input of a second FIFO instance.

Parameters:
- DATA_WIDTH, 32, word length in bits; minimum 4.
- LOG_DATA_WIDTH, 5, bit-counter width; 2^LOG_DATA_WIDTH >= DATA_WIDTH.
- FILL_WORD, 0, word shifted out on TX underrun.

Ports:
- clk_i  in  1  system clock; frequency >= 8x SPI SCLK frequency.
- rst_ni  in  1  asynchronous active-low reset.
- clr_i  in  1  synchronous clear: state, counters, rx_valid_o, sticky flags.
- spi_sclk_i  in  1  SPI clock, asynchronous to clk_i.
- spi_csn_i  in  1  chip select, active low, asynchronous.
- spi_mosi_i  in  1  serial data from master.
- spi_miso_o  out  1  serial data to master.
- spi_miso_oe_o  out  1  MISO output enable.
- tx_data_i  in  DATA_WIDTH  next word to transmit.
- tx_valid_i  in  1  tx_data_i is valid.
- tx_ready_o  out  1  TX word consumed this cycle.
- rx_data_o  out  DATA_WIDTH  received word.
- rx_valid_o  out  1  rx_data_o is valid.
- rx_ready_i  in  1  downstream accepts rx_data_o.
- busy_o  out  1  frame active (synchronized CS low).
- underrun_o  out  1  sticky: a word was loaded with tx_valid_i low.
- overflow_o  out  1  sticky: a received word was dropped.

Behaviour:
- Reset and clear values:
  - Reset (rst_ni low, asynchronous) with clock clk_i: synchronizer flops for sclk/mosi = 0, csn = 1; all outputs 0; state IDLE.
  - clr_i has the same effect as reset, but synchronously.
- Synchronization:
  - 2-flop synchronizer on each of sclk, csn, mosi, plus one delay flop on synchronized sclk and csn.
  - sclk_rise = s2 & ~d; sclk_fall = ~s2 & d; cs_fall = ~csn_s2 & csn_d; cs_rise = csn_s2 & ~csn_d.
- States: IDLE, ACTIVE.
  - IDLE -> ACTIVE on cs_fall; ACTIVE -> IDLE on cs_rise.
  - cs_rise has priority over any same-cycle sclk edge.
- TX load events: the cs_fall cycle, and the sclk_fall cycle following the DATA_WIDTH-th sclk_rise of a word while ACTIVE.
  - In a load cycle, tx_ready_o = 1 (combinational) and is 0 in all other cycles.
  - The shift register loads tx_data_i if tx_valid_i = 1. Otherwise it loads FILL_WORD and sets underrun_o.
- TX shift:
  - On every other sclk_fall while ACTIVE, the shift register shifts left with 0 fill.
  - spi_miso_o = shift[DATA_WIDTH-1] while ACTIVE, else 0.
  - spi_miso_oe_o = 1 exactly while ACTIVE.
- RX:
  - On sclk_rise while ACTIVE, rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s2} and bit_cnt increments.
  - On the DATA_WIDTH-th rise, bit_cnt wraps to 0 and the word completes.
  - The completed word goes to the rx holding register in the next cycle (latency 1 clk after that sclk_rise cycle).
- RX handshake: transfer occurs when rx_valid_o & rx_ready_i. Outcomes when a word completes:
  - Holder free, or freed in the same cycle: load the word, rx_valid_o = 1.
  - Holder full and not freed: keep the old word, drop the new one, set overflow_o.
  - No completion but transfer: rx_valid_o <= 0.
- Abort:
  - cs_rise mid-word discards the partial RX word and zeroes bit_cnt.
  - A TX word already loaded counts as consumed.
  - No flag is raised for an abort.
- Reset mid-frame: immediate IDLE; CS must be re-asserted by the master to start a new frame.
- Sticky flags clear only on clr_i or reset.

Test Plan:
- Single frame: DATA_WIDTH=32; tx_data_i=0xA5A50F0F valid before CS falls; master sends 0x12345678 at clk/10.
  - MISO bits = A5A50F0F MSB-first.
  - tx_ready_o pulses once.
  - rx_valid_o=1, rx_data_o=0x12345678 within 4 clk of the last SCLK rise.
- Back-to-back: one CS, 64 SCLKs, tx words 0x00000001 then 0x00000002.
  - The second tx_ready_o pulse lands on the falling edge after bit 32.
  - MISO carries both words.
  - The RX stream yields two words in order.
- Underrun: FILL_WORD=0xFFFFFFFF, tx_valid_i=0 at CS fall.
  - MISO is all 1s and underrun_o=1.
  - underrun_o stays 1 until a clr_i pulse, which returns it to 0.
- Overflow: rx_ready_i=0, two 32-bit words 0x11111111 and 0x22222222.
  - rx_data_o=0x11111111 and overflow_o=1.
  - After rx_ready_i=1 for one cycle, rx_valid_o=0.
- Abort: CS rises after 10 SCLKs.
  - No rx_valid_o and busy_o=0.
  - The next full frame with 0xCAFEBABE is received correctly.
- Reset mid-frame: rst_ni low after 5 bits.
  - All outputs 0 and spi_miso_oe_o=0 asynchronously.
  - The next frame works normally.
